tt_response_checker: RTL and testbench
======================================

TT_RESPONSE_CHECKER -- requirements
Module: tt_response_checker

Interface
REQ-001 Parameter SETTLE, default 4, cycles each input vector is held before the response is sampled; legal range 1..15.
REQ-002 Parameter EXP_F, default 8'b1001_0110, expected f per vector; bit i is the expected value for {a,b,c}=i.
REQ-003 Parameter EXP_Q, default 8'b1110_1000, expected q per vector; bit i is the expected value for {a,b,c}=i.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 start  input  1  level sampled each edge; high in IDLE or DONE begins a run.
REQ-007 f_in  input  1  DUT response f.
REQ-008 q_in  input  1  DUT response q.
REQ-009 a, b, c  output  1 each  stimulus vector driven to the DUT; a is MSB.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  high from run completion until the next start or reset.
REQ-012 pass  output  1  high only when done=1 and err_count=0.
REQ-013 err_count  output  4  number of vectors with any mismatch, range 0..8.
REQ-014 fail_mask  output  8  bit i set when vector i mismatched.
REQ-015 first_fail_idx  output  3  lowest failing vector index; 0 when err_count=0.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 In IDLE with start=1 at edge E0, the FSM SHALL enter RUN, set idx=0, settle_cnt=0, {a,b,c}=000, busy=1, done=0, and clear err_count, fail_mask and first_fail_idx.
REQ-018 In RUN, {a,b,c} SHALL equal idx, held constant for exactly SETTLE cycles per vector.
REQ-019 Each edge in RUN, settle_cnt SHALL increment; at the edge where settle_cnt=SETTLE-1, the block SHALL sample f_in and q_in, compare them against EXP_F[idx] and EXP_Q[idx], reset settle_cnt to 0, and advance idx.
REQ-020 A mismatch on f, q or both SHALL count as one failing vector: err_count increments by 1 and fail_mask[idx] is set.
REQ-021 first_fail_idx SHALL be loaded only on the first mismatch of a run.
REQ-022 The compare for idx=7 SHALL occur at edge E0+8*SETTLE; at that same edge the FSM SHALL enter DONE with busy=0, done=1, and err_count/fail_mask including vector 7.
REQ-023 In IDLE and DONE, {a,b,c} SHALL be 000.
REQ-024 In DONE, err_count, fail_mask and first_fail_idx SHALL hold their values.
REQ-025 start SHALL be ignored while in RUN, including when held high continuously.
REQ-026 start=1 in DONE SHALL begin a new run with the same actions as from IDLE (REQ-017).
REQ-027 With SETTLE=1, a new vector and a sample SHALL occur on every cycle, giving a total run of 8 cycles.
REQ-028 err_count SHALL never exceed 8, and no wrap-around SHALL occur.

Reset
REQ-029 With rst_n=0 at an edge, the block SHALL enter IDLE with {a,b,c}=000, busy=0, done=0, pass=0, err_count=0, fail_mask=8'h00, first_fail_idx=0, idx=0 and settle_cnt=0.
REQ-030 Reset SHALL override start and SHALL take effect in any state, including mid-run; no partial results are retained.

Verification
REQ-031 rst_n low for 2 cycles with start=1 -> all outputs at REQ-029 values, and the FSM stays in IDLE.
REQ-032 Golden model (f=a^b^c, q=majority), SETTLE=4, one-cycle start pulse -> abc steps 000..111 with each vector held 4 cycles; busy high for 32 cycles; done=1 and pass=1 after edge E0+32; err_count=0; fail_mask=8'h00.
REQ-033 f_in stuck at 0, q correct -> err_count=4, fail_mask=8'b1001_0110, first_fail_idx=1, pass=0.
REQ-034 q_in inverted, f correct -> err_count=8, fail_mask=8'hFF, first_fail_idx=0, pass=0.
REQ-035 rst_n pulsed low at cycle 10 of a failing run -> REQ-029 values at the next edge; a following start with the golden model yields pass=1 and err_count=0.
REQ-036 start held high for the whole run, then raised again in DONE -> the first run completes unaffected; the restart clears done, err_count and fail_mask at the edge start is sampled, then repeats the 32-cycle sequence.

Source files
------------

// File: rtl/tt_response_checker.sv
// tt_response_checker: steps {a,b,c} through 000..111, holding each vector
// for SETTLE cycles, and on the last held cycle compares the responses f_in
// and q_in against the expected truth tables EXP_F and EXP_Q. A run
// accumulates a per-vector fail mask, a failing-vector count and the index of
// the first failure. These results hold in DONE until the next run starts.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   start          begins a run when sampled high in IDLE or DONE
//   f_in, q_in     responses from the device under test
//   a, b, c        stimulus vector (a is the MSB)
//   busy           high while a run is in progress
//   done           high from run completion until the next start or reset
//   pass           done with no failing vectors
//   err_count      number of failing vectors (0..8)
//   fail_mask      bit i set when vector i failed
//   first_fail_idx lowest failing vector index (0 when there are no failures)
module tt_response_checker #(
  parameter int unsigned SETTLE = 4,
  parameter logic [7:0]  EXP_F  = 8'b1001_0110,
  parameter logic [7:0]  EXP_Q  = 8'b1110_1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       f_in,
  input  logic       q_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_mask,
  output logic [2:0] first_fail_idx
);

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned SETTLE_W = 4;
  localparam int unsigned ERR_W    = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

  logic [1:0]          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [7:0]          mask_q, mask_d;
  logic [IDX_W-1:0]    ffi_q, ffi_d;
  logic [2:0]          abc_q, abc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                mismatch;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      mask_q   <= '0;
      ffi_q    <= '0;
      abc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      mask_q   <= mask_d;
      ffi_q    <= ffi_d;
      abc_q    <= abc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  // Next-state, compare and next-output logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    err_d    = err_q;
    mask_d   = mask_q;
    ffi_d    = ffi_q;
    mismatch = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          idx_d    = '0;
          settle_d = '0;
          err_d    = '0;
          mask_d   = '0;
          ffi_d    = '0;
        end
      end
      RUN: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          mismatch = (f_in != EXP_F[idx_q]) || (q_in != EXP_Q[idx_q]);
          if (mismatch) begin
            // Only 8 vectors per run, so the count tops out at 8 without wrap
            err_d         = err_q + ERR_W'(1);
            mask_d[idx_q] = 1'b1;
            if (err_q == '0) begin
              ffi_d = idx_q;
            end
          end
          if (idx_q == IDX_W'(7)) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == '0);
    abc_d  = busy_d ? idx_d : 3'b000;
  end

  assign a              = abc_q[2];
  assign b              = abc_q[1];
  assign c              = abc_q[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_mask      = mask_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_tt_response_checker.sv
// Directed bench for tt_response_checker with a behavioural responder
// (golden, f stuck-at-0, q inverted) and a queue of expected run results.
module tb_tt_response_checker;

  typedef struct packed {
    logic [3:0] err;
    logic [7:0] mask;
    logic [2:0] ffi;
    logic       pass;
  } result_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       f_in, q_in;
  logic       a, b, c;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] fail_mask;
  logic [2:0] first_fail_idx;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          mode     = 0;   // 0 golden, 1 f stuck at 0, 2 q inverted
  result_t     exp_q[$];

  tt_response_checker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .f_in           (f_in),
    .q_in           (q_in),
    .a              (a),
    .b              (b),
    .c              (c),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .fail_mask      (fail_mask),
    .first_fail_idx (first_fail_idx)
  );

  always #5 clk = ~clk;

  // Responder: golden is f = parity, q = majority
  always_comb begin
    f_in = a ^ b ^ c;
    q_in = (a & b) | (a & c) | (b & c);
    if (mode == 1) f_in = 1'b0;
    if (mode == 2) q_in = ~q_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Bench-side model of a full run for the given responder mode
  function automatic result_t model_run(input int m);
    result_t r;
    logic    gf, gq, rf, rq;
    logic [2:0] v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      v  = 3'(i);
      gf = v[2] ^ v[1] ^ v[0];
      gq = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
      rf = (m == 1) ? 1'b0 : gf;
      rq = (m == 2) ? ~gq : gq;
      if (rf != gf || rq != gq) begin
        if (r.err == 0) r.ffi = v;
        r.err     = r.err + 4'd1;
        r.mask[i] = 1'b1;
      end
    end
    r.pass = (r.err == 0);
    return r;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_abc"},  {29'd0, a, b, c}, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_err"},  32'(err_count), 32'd0);
    chk({tag, "_mask"}, 32'(fail_mask), 32'd0);
    chk({tag, "_ffi"},  32'(first_fail_idx), 32'd0);
  endtask

  // Full run: start sampled at E0, 32 busy cycles, results after E0+32.
  // Called with start possibly already high (restart from DONE).
  task automatic do_run(input int m, input bit hold_start);
    result_t e;
    mode  = m;
    start = 1'b1;
    exp_q.push_back(model_run(m));
    @(posedge clk); #1;
    chk("start_done_clr", 32'(done), 32'd0);
    chk("start_err_clr",  32'(err_count), 32'd0);
    chk("start_mask_clr", 32'(fail_mask), 32'd0);
    for (int n = 0; n < 32; n++) begin
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_abc",  {29'd0, a, b, c}, 32'(n / 4));
      if (!hold_start) start = 1'b0;
      @(posedge clk); #1;
    end
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_done", 32'(done), 32'd1);
    chk("end_abc",  {29'd0, a, b, c}, 32'd0);
    chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("end_err",  32'(err_count), 32'(e.err));
      chk("end_mask", 32'(fail_mask), 32'(e.mask));
      chk("end_ffi",  32'(first_fail_idx), 32'(e.ffi));
      chk("end_pass", 32'(pass), 32'(e.pass));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    // Reset held 2 cycles with start high
    @(posedge clk); #1;
    chk_reset_vals("rst1");
    @(posedge clk); #1;
    chk_reset_vals("rst2");
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("idle");

    do_run(0, 1'b0);                 // golden
    // Results hold in DONE
    repeat (3) @(posedge clk);
    #1;
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_pass", 32'(pass), 32'd1);

    do_run(1, 1'b0);                 // f stuck at 0
    do_run(2, 1'b0);                 // q inverted

    // Reset in the middle of a failing run
    mode  = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_err",  32'(err_count), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("midrst");
    rst_n = 1'b1;
    do_run(0, 1'b0);

    // start held through a run, then restart from DONE with start still high
    do_run(0, 1'b1);
    do_run(0, 1'b0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
